// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and opcode constants for the K&S data path.
//   alu_op_t                 - 3-bit ALU operation select
//   mem_state_t              - memory sequencer states
//   decoded_instruction_type - decoded instruction presented to the control unit
//   OP_*                     - instruction opcodes (IR[15:8])
package k_and_s_pkg;

  typedef enum logic [2:0] {
    ALU_OR   = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_DONE
  } mem_state_t;

  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SHL, I_SHR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_XOR    = 8'hA5;
  localparam logic [7:0] OP_SHL    = 8'hA6;
  localparam logic [7:0] OP_SHR    = 8'hA7;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_HALT   = 8'hFF;

endpackage

// File: rtl/ks_alu.sv
// ks_alu: combinational 8-operation ALU with raw (unregistered) flags.
//   a, b    in  DATA_W  operands (SUB computes a - b; shifts and PASS use a)
//   op      in  3       alu_op_t
//   result  out DATA_W  operation result
//   zero, neg, uo, so  out  result == 0, result MSB, unsigned / signed overflow
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              uo,
  output logic              so
);

  localparam int MSB = DATA_W - 1;

  // One extra bit: carry-out for ADD, borrow (a < b unsigned) for SUB.
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    uo     = 1'b0;
    so     = 1'b0;
    case (op)
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result = sum[MSB:0];
        uo     = sum[DATA_W];
        so     = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = diff[MSB:0];
        uo     = diff[DATA_W];
        so     = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        uo     = a[MSB];
      end
      ALU_SHR: begin
        result = {1'b0, a[MSB:1]};
        uo     = a[0];
      end
      ALU_PASS: result = a;
      default:  result = '0;
    endcase
    zero = (result == '0);
    neg  = result[MSB];
  end

endmodule

// File: rtl/ks_param_data_path.sv
// ks_param_data_path: K&S processor data path (IR, PC, register file, ALU with
// registered flags, handshaked memory sequencer). All actions are gated by
// control-unit strobes; no control flow is executed here.
//   clk, rst_n            clock; rst_n is asynchronous and active HIGH
//   branch, pc_enable     PC load: branch ? IR mem field : PC + 1
//   ir_enable             IR <= MDR[15:0]
//   addr_sel              memory address source: 1 = IR mem field, 0 = PC
//   c_sel                 register write data: 1 = MDR, 0 = ALU result
//   write_reg_enable      write bus_c into register c
//   flags_reg_enable      capture all four ALU flags
//   operation             ALU operation (alu_op_t)
//   mem_start, mem_write  start a transaction (sampled in IDLE only)
//   mem_done, mem_busy    completion pulse / sequencer not idle
//   decoded_instruction   decode of IR[15:8]
//   zero_op, neg_op, unsigned_overflow, signed_overflow  registered flags
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack  memory port
module ks_param_data_path
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int REG_AW = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  alu_op_t                 operation,
  input  logic                    mem_start,
  input  logic                    mem_write,
  output logic                    mem_done,
  output logic                    mem_busy,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack
);

  localparam int NUM_REGS = 2 ** REG_AW;

  // All instruction fields must fit in the low byte of the 16-bit IR.
  if (ADDR_W + REG_AW > 8 || 3 * REG_AW > 8 || DATA_W < 16) begin : g_bad_params
    $error("ks_param_data_path: illegal DATA_W/ADDR_W/REG_AW combination");
  end

  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [REG_AW-1:0] a_idx, b_idx, c_idx;
  logic [ADDR_W-1:0] mem_field;
  logic              alu_fmt;
  logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_out;
  logic              alu_zero, alu_neg, alu_uo, alu_so;

  mem_state_t state, state_nxt;

  // Not every IR bit is a field for every parameter set.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir;

  // ---------------- decode ----------------
  assign mem_field = ir[ADDR_W-1:0];

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see the
    // values assigned above them in the same pass.
    decoded_instruction = I_NOP;
    alu_fmt             = 1'b0;
    a_idx               = '0;
    b_idx               = '0;
    c_idx               = '0;
    case (ir[15:8])
      OP_LOAD: begin
        decoded_instruction = I_LOAD;
        c_idx               = ir[ADDR_W+REG_AW-1:ADDR_W];
      end
      OP_STORE: begin
        decoded_instruction = I_STORE;
        a_idx               = ir[ADDR_W+REG_AW-1:ADDR_W];
      end
      OP_MOVE: begin
        decoded_instruction = I_MOVE;
        a_idx               = ir[REG_AW-1:0];
        b_idx               = ir[REG_AW-1:0];
        c_idx               = ir[2*REG_AW-1:REG_AW];
      end
      OP_ADD:    begin decoded_instruction = I_ADD; alu_fmt = 1'b1; end
      OP_SUB:    begin decoded_instruction = I_SUB; alu_fmt = 1'b1; end
      OP_AND:    begin decoded_instruction = I_AND; alu_fmt = 1'b1; end
      OP_OR:     begin decoded_instruction = I_OR;  alu_fmt = 1'b1; end
      OP_XOR:    begin decoded_instruction = I_XOR; alu_fmt = 1'b1; end
      OP_SHL:    begin decoded_instruction = I_SHL; alu_fmt = 1'b1; end
      OP_SHR:    begin decoded_instruction = I_SHR; alu_fmt = 1'b1; end
      OP_BRANCH: decoded_instruction = I_BRANCH;
      OP_BZERO:  decoded_instruction = I_BZERO;
      OP_BNEG:   decoded_instruction = I_BNEG;
      OP_BOV:    decoded_instruction = I_BOV;
      OP_BNOV:   decoded_instruction = I_BNOV;
      OP_BNNEG:  decoded_instruction = I_BNNEG;
      OP_BNZERO: decoded_instruction = I_BNZERO;
      OP_HALT:   decoded_instruction = I_HALT;
      default:   decoded_instruction = I_NOP;
    endcase
    if (alu_fmt) begin
      a_idx = ir[REG_AW-1:0];
      b_idx = ir[2*REG_AW-1:REG_AW];
      c_idx = ir[3*REG_AW-1:2*REG_AW];
    end
  end

  // ---------------- register file and ALU ----------------
  assign bus_a = regs[a_idx];
  assign bus_b = regs[b_idx];
  assign bus_c = c_sel ? mdr : alu_out;

  ks_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (bus_a),
    .b      (bus_b),
    .op     (operation),
    .result (alu_out),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .uo     (alu_uo),
    .so     (alu_so)
  );

  // NOTE: this register array is small and architecturally visible, so it is
  // reset like any flop; a large RAM-style array would be left unreset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // pre-edge values; a same-cycle read of regs[c_idx] sees the old data.
      regs[c_idx] <= bus_c;
    end
  end

  // ---------------- PC, IR, flags ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc                <= '0;
      ir                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else begin
      if (pc_enable) pc <= branch ? mem_field : pc + ADDR_W'(1);
      if (ir_enable) ir <= mdr[15:0];
      if (flags_reg_enable) begin
        zero_op           <= alu_zero;
        neg_op            <= alu_neg;
        unsigned_overflow <= alu_uo;
        signed_overflow   <= alu_so;
      end
    end
  end

  // ---------------- memory sequencer ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= MEM_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (mem_start) state_nxt = MEM_REQ;
      MEM_REQ:  if (mem_ack)   state_nxt = MEM_DONE;
      MEM_DONE: state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // Request qualifiers are decoded from the state register so reset drops
  // mem_req immediately, even in the middle of a transaction.
  assign mem_req  = (state == MEM_REQ);
  assign mem_done = (state == MEM_DONE);
  assign mem_busy = (state != MEM_IDLE);

  // Address, direction and write data are latched at start and held stable
  // for the whole request; reads land in MDR on the acknowledging edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mdr       <= '0;
    end else begin
      if (state == MEM_IDLE && mem_start) begin
        mem_addr  <= addr_sel ? mem_field : pc;
        mem_we    <= mem_write;
        mem_wdata <= bus_a;
      end
      if (state == MEM_REQ && mem_ack && !mem_we) mdr <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ks_param_data_path.sv
// Directed bench for ks_param_data_path. Two instances share all strobes: the
// default 16-bit build and a 32-bit build (REG_AW=2, ADDR_W=5, which keeps the
// same instruction encoding), so the wide instance executes identical programs.
module tb_ks_param_data_path;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0, addr_sel = 1'b0;
  logic c_sel = 1'b0, write_reg_enable = 1'b0, flags_reg_enable = 1'b0;
  logic mem_start = 1'b0, mem_write = 1'b0, mem_ack = 1'b0;
  alu_op_t     operation = ALU_OR;
  logic [15:0] mem_rdata = '0;
  logic [31:0] mem_rdata_w = '0;

  logic mem_done, mem_busy, zero_op, neg_op, uo, so, mem_req, mem_we;
  decoded_instruction_type dec;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;

  logic mem_done_w, mem_busy_w, zero_w, neg_w, uo_w, so_w, mem_req_w, mem_we_w;
  decoded_instruction_type dec_w;
  logic [4:0]  mem_addr_w;
  logic [31:0] mem_wdata_w;

  int n_vec  = 0;
  int n_miss = 0;

  ks_param_data_path #(.DATA_W(16), .ADDR_W(5), .REG_AW(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .operation(operation), .mem_start(mem_start), .mem_write(mem_write),
    .mem_done(mem_done), .mem_busy(mem_busy), .decoded_instruction(dec),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uo),
    .signed_overflow(so), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  ks_param_data_path #(.DATA_W(32), .ADDR_W(5), .REG_AW(2)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .operation(operation), .mem_start(mem_start), .mem_write(mem_write),
    .mem_done(mem_done_w), .mem_busy(mem_busy_w), .decoded_instruction(dec_w),
    .zero_op(zero_w), .neg_op(neg_w), .unsigned_overflow(uo_w),
    .signed_overflow(so_w), .mem_req(mem_req_w), .mem_we(mem_we_w),
    .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .mem_rdata(mem_rdata_w),
    .mem_ack(mem_ack)
  );

  // ALU sweep on r3=0xC3A5, r2=0x0F0F; flags packed {zero, neg, uo, so}.
  alu_op_t     tbl_op  [5] = '{ALU_OR, ALU_AND, ALU_XOR, ALU_SHL, ALU_PASS};
  logic [15:0] tbl_res [5] = '{16'hCFAF, 16'h0305, 16'hCCAA, 16'h874A, 16'hC3A5};
  logic [3:0]  tbl_flg [5] = '{4'b0100, 4'b0000, 4'b0100, 4'b0110, 4'b0100};

  logic [7:0]              tbl_opc [8] = '{8'h82, 8'hA5, 8'hA6, 8'hA7, 8'h0B, 8'hFF, 8'h50, 8'h0A};
  decoded_instruction_type tbl_dec [8] = '{I_STORE, I_XOR, I_SHL, I_SHR, I_BNZERO, I_HALT, I_NOP, I_BNNEG};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'b0, zero_op, neg_op, uo, so}, {28'b0, exp});
  endtask

  task automatic mem_txn(input logic wr, input logic asel, input int delay,
                         input logic [15:0] rd, input logic [31:0] rdw);
    mem_write = wr;
    addr_sel  = asel;
    mem_start = 1'b1;
    tick;
    mem_start = 1'b0;
    check("txn_req", 32'(mem_req), 32'd1);
    repeat (delay) tick;
    mem_rdata   = rd;
    mem_rdata_w = rdw;
    mem_ack     = 1'b1;
    tick;
    mem_ack = 1'b0;
    check("txn_done", 32'(mem_done), 32'd1);
    tick;
  endtask

  task automatic fetch_ir(input logic [15:0] instr);
    mem_txn(1'b0, 1'b0, 0, instr, {16'h0, instr});
    ir_enable = 1'b1;
    tick;
    ir_enable = 1'b0;
  endtask

  // LOAD-style register write: IR = LOAD rIdx, data read into MDR, bus_c = MDR.
  task automatic write_reg(input int idx, input logic [15:0] d, input logic [31:0] dw);
    fetch_ir(16'h8100 | 16'(idx << 5));
    mem_txn(1'b0, 1'b1, 0, d, dw);
    c_sel            = 1'b1;
    write_reg_enable = 1'b1;
    tick;
    c_sel            = 1'b0;
    write_reg_enable = 1'b0;
  endtask

  // STORE rIdx exposes the register on mem_wdata.
  task automatic store_check(input int idx, input logic [15:0] e16,
                             input logic [31:0] e32, input bit chk_w);
    fetch_ir(16'h8200 | 16'(idx << 5));
    mem_write = 1'b1;
    addr_sel  = 1'b1;
    mem_start = 1'b1;
    tick;
    mem_start = 1'b0;
    check("st_we", 32'(mem_we), 32'd1);
    check("st_wdata", 32'(mem_wdata), 32'(e16));
    if (chk_w) check("st_wdata_w", mem_wdata_w, e32);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    tick;
  endtask

  task automatic alu_exec(input alu_op_t op, input logic fen);
    operation        = op;
    flags_reg_enable = fen;
    write_reg_enable = 1'b1;
    c_sel            = 1'b0;
    tick;
    flags_reg_enable = 1'b0;
    write_reg_enable = 1'b0;
  endtask

  task automatic addr_probe(input string tag, input logic [4:0] exp);
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    mem_start = 1'b1;
    tick;
    mem_start = 1'b0;
    check(tag, 32'(mem_addr), 32'(exp));
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    tick;
  endtask

  initial begin
    int done_cnt;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    repeat (2) tick;
    // ---- reset state ----
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    check("rst_dec", 32'(dec), 32'(I_NOP));
    check_flags("rst_flags", 4'b0000);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata_w", mem_wdata_w, 32'd0);
    rst_n = 1'b0;
    tick;

    // ---- fetch from PC=3 with ack delayed 4 cycles ----
    pc_enable = 1'b1;
    repeat (3) tick;
    pc_enable = 1'b0;
    addr_sel  = 1'b0;
    mem_write = 1'b0;
    mem_start = 1'b1;
    tick;
    mem_start = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      check("fetch_addr", 32'(mem_addr), 32'd3);
      check("fetch_req", 32'(mem_req), 32'd1);
      done_cnt += int'(mem_done);
      tick;
    end
    mem_rdata   = 16'hA11B;
    mem_rdata_w = 32'h0000A11B;
    mem_ack     = 1'b1;
    tick;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_cnt += int'(mem_done);
      tick;
    end
    check("fetch_done_pulses", done_cnt, 1);
    check("fetch_idle", 32'(mem_busy), 32'd0);
    ir_enable = 1'b1;
    tick;
    ir_enable = 1'b0;
    check("dec_add", 32'(dec), 32'(I_ADD));

    // ---- ADD / SUB with flags (ADD r1 = r3 + r2) ----
    write_reg(3, 16'h7FFF, 32'h7FFF);
    write_reg(2, 16'h0001, 32'h0001);
    fetch_ir(16'hA11B);
    alu_exec(ALU_ADD, 1'b1);
    check_flags("add_sovf_flags", 4'b0101);
    store_check(1, 16'h8000, 32'h0, 1'b0);

    write_reg(3, 16'hFFFF, 32'hFFFF);
    fetch_ir(16'hA11B);
    alu_exec(ALU_ADD, 1'b1);
    check_flags("add_carry_flags", 4'b1010);
    store_check(1, 16'h0000, 32'h0, 1'b0);

    write_reg(3, 16'h0000, 32'h0);
    fetch_ir(16'hA11B);
    alu_exec(ALU_SUB, 1'b1);
    check_flags("sub_borrow_flags", 4'b0110);
    store_check(1, 16'hFFFF, 32'h0, 1'b0);

    fetch_ir(16'hA11B);
    alu_exec(ALU_ADD, 1'b0);
    check_flags("flags_hold", 4'b0110);
    store_check(1, 16'h0001, 32'h0, 1'b0);

    // ---- logic / shift / pass sweep ----
    write_reg(3, 16'hC3A5, 32'hC3A5);
    write_reg(2, 16'h0F0F, 32'h0F0F);
    for (int i = 0; i < 5; i++) begin
      fetch_ir(16'hA11B);
      alu_exec(tbl_op[i], 1'b1);
      check_flags($sformatf("alu_flags_%0d", i), tbl_flg[i]);
      store_check(1, tbl_res[i], 32'h0, 1'b0);
    end

    // ---- STORE, start ignored while busy, ack ignored while idle ----
    write_reg(2, 16'h1234, 32'h1234);
    fetch_ir(16'h8245);
    check("dec_store", 32'(dec), 32'(I_STORE));
    mem_write = 1'b1;
    addr_sel  = 1'b1;
    mem_start = 1'b1;
    tick;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    check("store_we", 32'(mem_we), 32'd1);
    check("store_addr", 32'(mem_addr), 32'd5);
    check("store_wdata", 32'(mem_wdata), 32'h1234);
    tick;
    check("busy_start_addr", 32'(mem_addr), 32'd5);
    check("busy_start_we", 32'(mem_we), 32'd1);
    mem_start = 1'b0;
    mem_ack   = 1'b1;
    tick;
    mem_ack   = 1'b0;
    mem_start = 1'b1;
    check("store_done", 32'(mem_done), 32'd1);
    tick;
    mem_start = 1'b0;
    check("done_start_ignored", 32'(mem_busy), 32'd0);
    check("store_addr_kept", 32'(mem_addr), 32'd5);
    mem_ack = 1'b1;
    tick;
    tick;
    mem_ack = 1'b0;
    check("idle_ack_busy", 32'(mem_busy), 32'd0);
    check("idle_ack_done", 32'(mem_done), 32'd0);

    // ---- same-edge write and read of r1 (MOVE r1: a=b=c=1) ----
    write_reg(1, 16'h1111, 32'h1111);
    fetch_ir(16'h9105);
    check("dec_move", 32'(dec), 32'(I_MOVE));
    mem_write        = 1'b1;
    addr_sel         = 1'b1;
    mem_start        = 1'b1;
    c_sel            = 1'b1;
    write_reg_enable = 1'b1;
    tick;
    mem_start        = 1'b0;
    c_sel            = 1'b0;
    write_reg_enable = 1'b0;
    check("rw_old_value", 32'(mem_wdata), 32'h1111);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    tick;
    store_check(1, 16'h9105, 32'h0, 1'b0);

    // ---- decode table ----
    for (int i = 0; i < 8; i++) begin
      fetch_ir({tbl_opc[i], 8'h00});
      check($sformatf("dec_%02h", tbl_opc[i]), 32'(dec), 32'(tbl_dec[i]));
    end

    // ---- 32-bit instance: SHR r1 = r3 >> 1 ----
    write_reg(3, 16'hBEEF, 32'hDEADBEEF);
    fetch_ir(16'hA713);
    alu_exec(ALU_SHR, 1'b1);
    check("shr_flags_w", {28'b0, zero_w, neg_w, uo_w, so_w}, 32'b0010);
    check_flags("shr_flags", 4'b0010);
    store_check(1, 16'h5F77, 32'h6F56DF77, 1'b1);

    // ---- PC branch to 31 then wrap to 0 ----
    fetch_ir(16'h011F);
    check("dec_branch", 32'(dec), 32'(I_BRANCH));
    branch    = 1'b1;
    pc_enable = 1'b1;
    tick;
    branch    = 1'b0;
    pc_enable = 1'b0;
    addr_probe("pc_branch", 5'd31);
    pc_enable = 1'b1;
    tick;
    pc_enable = 1'b0;
    addr_probe("pc_wrap", 5'd0);
    pc_enable = 1'b1;
    repeat (2) tick;
    pc_enable = 1'b0;

    // ---- reset in the middle of a request ----
    fetch_ir(16'hA713);
    alu_exec(ALU_SHR, 1'b1);
    addr_sel  = 1'b0;
    mem_write = 1'b0;
    mem_start = 1'b1;
    tick;
    mem_start = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    check("pre_rst_addr", 32'(mem_addr), 32'd2);
    rst_n = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_req_w", 32'(mem_req_w), 32'd0);
    check("mid_rst_busy", 32'(mem_busy), 32'd0);
    check_flags("mid_rst_flags", 4'b0000);
    tick;
    rst_n = 1'b0;
    tick;
    addr_probe("rst_pc", 5'd0);
    store_check(1, 16'h0000, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
